// File: rtl/down_counter_pkg.sv
// Shared types and constants for the loadable down-counter.
// Optional periodic reload is enabled by defining DOWN_COUNTER_RELOAD_EN.
package down_counter_pkg;

  localparam int unsigned DOWN_COUNTER_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter with valid/ready load, one-cycle done pulse and wrapping expiry tally.
// Define DOWN_COUNTER_RELOAD_EN to build the reload register for periodic done pulses.
module down_counter
  import down_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DOWN_COUNTER_DEFAULT_WIDTH
) (
  input  logic             aclk,
  input  logic             srst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clr,
  input  logic             dec,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] expired
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] expired_q, expired_d;
  logic             load_ready_q, load_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef DOWN_COUNTER_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // State and registered outputs
  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q      <= IDLE;
      out_q        <= '0;
      expired_q    <= '0;
      load_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef DOWN_COUNTER_RELOAD_EN
      reload_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      expired_q    <= expired_d;
      load_ready_q <= load_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef DOWN_COUNTER_RELOAD_EN
      reload_q     <= reload_d;
`endif
    end
  end

  // Next state and datapath; clr overrides any load or decrement
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    expired_d = expired_q;
`ifdef DOWN_COUNTER_RELOAD_EN
    reload_d  = reload_q;
`endif
    if (clr) begin
      state_d  = IDLE;
      out_d    = '0;
`ifdef DOWN_COUNTER_RELOAD_EN
      reload_d = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (load_valid) begin
`ifdef DOWN_COUNTER_RELOAD_EN
            reload_d = load_value;
`endif
            if (load_value != '0) begin
              state_d = RUN;
              out_d   = load_value;
            end else begin
              state_d = DONE;
            end
          end
        end
        RUN: begin
          if (dec) begin
            out_d = out_q - WIDTH'(1);
            if (out_q == WIDTH'(1)) state_d = DONE;
          end
        end
        DONE: begin
          expired_d = expired_q + WIDTH'(1);
          state_d   = IDLE;
`ifdef DOWN_COUNTER_RELOAD_EN
          if (reload_q != '0) begin
            state_d = RUN;
            out_d   = reload_q;
          end
`endif
        end
        default: begin
          state_d = IDLE;
          out_d   = '0;
        end
      endcase
    end
    // Status flags are registered copies of the next state's decode
    load_ready_d = (state_d == IDLE);
    busy_d       = (state_d == RUN);
    done_d       = (state_d == DONE);
  end

  assign load_ready = load_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign out        = out_q;
  assign expired    = expired_q;

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: directed scenarios plus randomized traffic
// checked cycle by cycle against a behavioural budget model.
module tb_down_counter;

  localparam int unsigned W = 8;

  logic         aclk;
  logic         srst;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_value;
  logic         clr;
  logic         dec;
  logic [W-1:0] out;
  logic         busy;
  logic         done;
  logic [W-1:0] expired;

  int errors = 0;
  int checks = 0;

  // Behavioural model: remaining budget, running flag, expiry-pending flag, tally
  int m_out    = 0;
  int m_exp    = 0;
  int m_reload = 0;
  bit m_busy   = 0;
  bit m_done   = 0;

  down_counter #(.WIDTH(W)) dut (
    .aclk       (aclk),
    .srst       (srst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .clr        (clr),
    .dec        (dec),
    .out        (out),
    .busy       (busy),
    .done       (done),
    .expired    (expired)
  );

  initial begin
    aclk = 1'b0;
    forever #2 aclk = ~aclk;
  end

  function automatic void model_edge(input bit rst, input bit lv, input int val,
                                     input bit c, input bit d);
    if (rst) begin
      m_out = 0; m_exp = 0; m_reload = 0; m_busy = 0; m_done = 0;
    end else if (c) begin
      m_out = 0; m_reload = 0; m_busy = 0; m_done = 0;
    end else if (m_done) begin
      m_exp  = (m_exp + 1) % 256;
      m_done = 0;
`ifdef DOWN_COUNTER_RELOAD_EN
      if (m_reload != 0) begin
        m_busy = 1;
        m_out  = m_reload;
      end
`endif
    end else if (m_busy) begin
      if (d) begin
        m_out = m_out - 1;
        if (m_out == 0) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end else if (lv) begin
      m_reload = val;
      if (val != 0) begin
        m_busy = 1;
        m_out  = val;
      end else begin
        m_done = 1;
      end
    end
  endfunction

  // Apply inputs for one clock edge, advance the model, then settle past the edge
  task automatic cycle(input bit lv, input logic [W-1:0] val, input bit c,
                       input bit d, input bit rst);
    srst = rst; load_valid = lv; load_value = val; clr = c; dec = d;
    @(posedge aclk);
    model_edge(rst, lv, int'(val), c, d);
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 25; i++) cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({load_ready, busy, done, out, expired} !== {1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b busy=%b done=%b out=%0d exp=%0d, want 1 0 0 0 0",
               load_ready, busy, done, out, expired);
    end
  endtask

  task automatic test_basic_countdown();
    logic [W-1:0] want [4] = '{8'd3, 8'd2, 8'd1, 8'd0};
    cycle(1'b1, 8'd3, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out !== want[i] || done !== (i == 3) || busy !== (i != 3)) begin
        errors++;
        $display("FAIL countdown_step%0d: got out=%0d done=%b busy=%b, want out=%0d done=%b busy=%b",
                 i, out, done, busy, want[i], (i == 3), (i != 3));
      end
      if (i < 3) cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    end
    cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (done !== 1'b0 || expired !== 8'd1 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL countdown_after: got done=%b exp=%0d rdy=%b, want 0 1 1", done, expired, load_ready);
    end
  endtask

  task automatic test_zero_load();
    bit saw_busy = 0;
    cycle(1'b1, 8'd0, 1'b0, 1'b1, 1'b0);
    saw_busy |= busy;
    checks++;
    if (done !== 1'b1 || out !== 8'd0 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_load_done: got done=%b out=%0d rdy=%b, want 1 0 0", done, out, load_ready);
    end
    cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    saw_busy |= busy;
    checks++;
    if (expired !== 8'd2 || saw_busy || done !== 1'b0) begin
      errors++;
      $display("FAIL zero_load_after: got exp=%0d busy_seen=%b done=%b, want 2 0 0", expired, saw_busy, done);
    end
  endtask

  task automatic test_clear_mid_count();
    cycle(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (out !== 8'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_pre: got out=%0d busy=%b, want 3 1", out, busy);
    end
    cycle(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({load_ready, busy, done, out, expired} !== {1'b1, 1'b0, 1'b0, 8'd0, 8'd2}) begin
      errors++;
      $display("FAIL clear_mid: got rdy=%b busy=%b done=%b out=%0d exp=%0d, want 1 0 0 0 2",
               load_ready, busy, done, out, expired);
    end
  endtask

  task automatic test_load_with_clr();
    cycle(1'b1, 8'd7, 1'b1, 1'b0, 1'b0);
    checks++;
    if (load_ready !== 1'b1 || busy !== 1'b0 || out !== 8'd0) begin
      errors++;
      $display("FAIL load_with_clr: got rdy=%b busy=%b out=%0d, want 1 0 0", load_ready, busy, out);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (load_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got rdy=%b done=%b, want 1 0", load_ready, done);
    end
    cycle(1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1 || out !== 8'd3) begin
      errors++;
      $display("FAIL b2b_load: got busy=%b out=%0d, want 1 3", busy, out);
    end
    cycle(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_count();
    cycle(1'b1, 8'd9, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({load_ready, busy, done, out, expired} !== {1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset_mid: got rdy=%b busy=%b done=%b out=%0d exp=%0d, want 1 0 0 0 0",
               load_ready, busy, done, out, expired);
    end
  endtask

  task automatic test_expiry_wrap();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      cycle(1'b1, 8'd1, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
      if (done === 1'b1) pulses++;
      cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      if (m_busy) cycle(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
      if (i == 254) begin
        checks++;
        if (expired !== 8'd255) begin
          errors++;
          $display("FAIL wrap_255: got exp=%0d, want 255", expired);
        end
      end
    end
    checks++;
    if (expired !== 8'd0 || pulses != 256) begin
      errors++;
      $display("FAIL wrap_final: got exp=%0d pulses=%0d, want 0 256", expired, pulses);
    end
  endtask

`ifdef DOWN_COUNTER_RELOAD_EN
  task automatic test_reload();
    logic [9:0] seen = '0;
    do_reset();
    cycle(1'b1, 8'd2, 1'b0, 1'b1, 1'b0);
    seen[0] = done;
    for (int i = 1; i < 10; i++) begin
      cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
      seen[i] = done;
    end
    checks++;
    if (seen !== 10'b01_0010_0100) begin
      errors++;
      $display("FAIL reload_pattern: got %b, want 0100100100", seen);
    end
    cycle(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (load_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reload_clr: got rdy=%b done=%b busy=%b, want 1 0 0", load_ready, done, busy);
    end
  endtask
`endif

  task automatic test_random();
    logic [18:0] act, exp_v;
    bit lv, c, d, r;
    logic [W-1:0] val;
    for (int i = 0; i < 600; i++) begin
      lv  = ($urandom_range(0, 1) == 1);
      val = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 20)) : W'($urandom_range(0, 4));
      c   = ($urandom_range(0, 15) == 0);
      d   = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 99) == 0);
      cycle(lv, val, c, d, r);
      act   = {load_ready, busy, done, out, expired};
      exp_v = {!(m_busy || m_done), m_busy, m_done, W'(m_out), W'(m_exp)};
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL random_cyc%0d: got rdy/busy/done/out/exp=%b/%b/%b/%0d/%0d, want %b/%b/%b/%0d/%0d",
                 i, load_ready, busy, done, out, expired,
                 !(m_busy || m_done), m_busy, m_done, m_out, m_exp);
      end
    end
  endtask

  initial begin
    srst = 1'b1; load_valid = 1'b0; load_value = '0; clr = 1'b0; dec = 1'b0;
    test_reset();
    test_basic_countdown();
    test_zero_load();
    test_clear_mid_count();
    test_load_with_clr();
    test_back_to_back();
    test_reset_mid_count();
    test_expiry_wrap();
`ifdef DOWN_COUNTER_RELOAD_EN
    test_reload();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
